// File: rtl/adh_source_sequencer.sv
// Address-high source sequencer: steps through the operand/pointer fetch cycles of
// each addressing mode and selects which bus drives ADH in every cycle.
module adh_source_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [2:0] Mode,
  input  logic       Page_Cross,
  input  logic       Force_Fixup,
  input  logic       Stall,
  input  logic       Abort,
  output logic       PCH_ADH,
  output logic       SB_ADH,
  output logic       DL_ADH,
  output logic       Zero_ADH0,
  output logic       Zero_ADH1_7,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_LO,
    S_FETCH_HI,
    S_PTR_LO,
    S_PTR_HI,
    S_ZP_ACC,
    S_EFF,
    S_FIXUP
  } state_t;

  localparam logic [2:0] MODE_PC   = 3'd0;
  localparam logic [2:0] MODE_ZP   = 3'd1;
  localparam logic [2:0] MODE_ABS  = 3'd2;
  localparam logic [2:0] MODE_ABSX = 3'd3;
  localparam logic [2:0] MODE_INDZ = 3'd4;

  state_t     state_reg, state_next;
  logic [2:0] mode_reg, mode_next;
  logic       force_reg, force_next;
  logic       error_reg, error_next;
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  logic       fixup_take;
  logic       last_state;
  logic       done_int;
  logic       accept;
  logic       mode_legal;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_reg[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg <= S_IDLE;
      mode_reg  <= 3'd0;
      force_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      force_reg <= force_next;
      error_reg <= error_next;
    end
  end

  // Fix-up only exists for the indexed modes; Page_Cross is meaningless elsewhere.
  assign fixup_take = ((mode_reg == MODE_ABSX) || (mode_reg == MODE_INDZ)) &&
                      (Page_Cross || force_reg);

  always_comb begin
    last_state = 1'b0;
    case (state_reg)
      S_FETCH_LO: last_state = (mode_reg == MODE_PC);
      S_ZP_ACC:   last_state = 1'b1;
      S_EFF:      last_state = (mode_reg == MODE_ABS) || !fixup_take;
      S_FIXUP:    last_state = 1'b1;
      default:    last_state = 1'b0;
    endcase
  end

  assign done_int   = last_state && !Stall && !Abort;
  assign mode_legal = (Mode <= MODE_INDZ);
  assign accept     = Start && !Stall && !Abort && ((state_reg == S_IDLE) || done_int);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    force_next = force_reg;
    error_next = 1'b0;
    if (Abort) begin
      state_next = S_IDLE;
    end else if (Stall) begin
      state_next = state_reg;
    end else if (accept) begin
      if (mode_legal) begin
        state_next = S_FETCH_LO;
        mode_next  = Mode;
        force_next = Force_Fixup;
      end else begin
        state_next = S_IDLE;
        error_next = 1'b1;
      end
    end else if (done_int) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_FETCH_LO: begin
          if (mode_reg == MODE_ZP)        state_next = S_ZP_ACC;
          else if (mode_reg == MODE_INDZ) state_next = S_PTR_LO;
          else                            state_next = S_FETCH_HI;
        end
        S_FETCH_HI: state_next = S_EFF;
        S_PTR_LO:   state_next = S_PTR_HI;
        S_PTR_HI:   state_next = S_EFF;
        S_EFF:      state_next = S_FIXUP;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // Source selects are pure state decode, so they are one-hot by construction.
  always_comb begin
    PCH_ADH     = 1'b0;
    SB_ADH      = 1'b0;
    DL_ADH      = 1'b0;
    Zero_ADH0   = 1'b0;
    Zero_ADH1_7 = 1'b0;
    case (state_reg)
      S_FETCH_LO, S_FETCH_HI:     PCH_ADH = 1'b1;
      S_PTR_LO, S_PTR_HI, S_ZP_ACC: begin
        Zero_ADH0   = 1'b1;
        Zero_ADH1_7 = 1'b1;
      end
      S_EFF:   DL_ADH = 1'b1;
      S_FIXUP: SB_ADH = 1'b1;
      default: ;
    endcase
  end

  assign Busy  = (state_reg != S_IDLE);
  assign Done  = done_int;
  assign Error = error_reg;

endmodule

// File: doc/adh_source_sequencer.md
ADH_SOURCE_SEQUENCER -- requirements
Module: adh_source_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-002 The block SHALL have the following inputs:
- Start (1): request a new address-high sequence.
- Mode (3): addressing mode.
  - 0 = PC fetch
  - 1 = zero page
  - 2 = absolute
  - 3 = absolute indexed
  - 4 = indirect zero-page indexed
  - 5-7 = illegal
- Page_Cross (1): carry out of the low-address adder, valid in EFF.
- Force_Fixup (1): always take the fix-up cycle (indexed writes); sampled with Start.
- Stall (1): RDY low; freeze the sequence.
- Abort (1): cancel the sequence.
REQ-003 The block SHALL have the following outputs:
- PCH_ADH, SB_ADH, DL_ADH, Zero_ADH0, Zero_ADH1_7 (1 each): address-high source controls.
- Busy (1): sequence in progress.
- Done (1): final access cycle.
- Error (1): illegal-mode pulse.

Function
REQ-004 States SHALL be IDLE, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, ZP_ACC, EFF and FIXUP; encoding is free.
REQ-005 Output decode per state (all other controls 0):
- IDLE: all controls 0.
- FETCH_LO and FETCH_HI: PCH_ADH=1.
- PTR_LO, PTR_HI and ZP_ACC: Zero_ADH0=1 and Zero_ADH1_7=1.
- EFF: DL_ADH=1.
- FIXUP: SB_ADH=1.
REQ-006 At most one of PCH_ADH, SB_ADH and DL_ADH SHALL be 1 in any cycle, and the Zero controls SHALL never be 1 together with any of them.
REQ-007 Sequences SHALL be:
- Mode 0: FETCH_LO.
- Mode 1: FETCH_LO, ZP_ACC.
- Mode 2: FETCH_LO, FETCH_HI, EFF.
- Mode 3: FETCH_LO, FETCH_HI, EFF, [FIXUP].
- Mode 4: FETCH_LO, PTR_LO, PTR_HI, EFF, [FIXUP].
REQ-008 Mode and Force_Fixup SHALL be latched when Start is accepted; later changes to these inputs SHALL NOT affect the running sequence.
REQ-009 Start SHALL be accepted only in IDLE, or in a cycle where Done=1, with Stall=0 and Abort=0; the first state of the new sequence is entered on the next clock edge (1-cycle latency from IDLE).
REQ-010 Back-to-back operation: a Start accepted with Done=1 SHALL enter the next FETCH_LO directly, with no idle cycle between sequences.
REQ-011 In EFF for modes 3 and 4, FIXUP SHALL be entered next if Page_Cross=1 or the latched Force_Fixup=1; otherwise the sequence ends. Page_Cross SHALL be ignored in all other states and modes.
REQ-012 Done SHALL be 1 (Mealy) in the last state of the sequence only:
- FETCH_LO for mode 0
- ZP_ACC for mode 1
- EFF for mode 2
- EFF for modes 3/4 when no fix-up is taken
- FIXUP
REQ-013 After a Done cycle with no accepted Start, the state SHALL return to IDLE.
REQ-014 Busy SHALL be 1 in every state except IDLE.
REQ-015 Stall=1 SHALL hold the state and all control outputs unchanged, force Done=0, and block Start; with Stall=1 in IDLE, Start SHALL be ignored.
REQ-016 Abort=1 SHALL force IDLE on the next edge with no Done pulse. Abort has priority over Stall and Start.
REQ-017 Start with Mode 5-7 in IDLE SHALL leave the state in IDLE and produce Error=1 for exactly the next cycle; the same SHALL apply to an illegal Start in a Done cycle, where the state then goes to IDLE.
REQ-018 Start while Busy=1 and Done=0 SHALL be ignored, with no Error.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE with all controls, Busy, Done and Error at 0, and clear the latched Mode and Force_Fixup to 0.
REQ-020 Assertion of rst_n=0 mid-sequence SHALL discard the sequence; after release, no Done is produced until a new Start is accepted.
REQ-021 rst_n deassertion SHALL take effect synchronously to clk.

Verification
REQ-022 Mode 2 Start from IDLE -> 3 cycles:
- PCH_ADH=1, PCH_ADH=1, then DL_ADH=1 with Done=1.
- Then IDLE, all controls 0.
REQ-023 Mode 3 with Page_Cross=1 in EFF -> 4 cycles:
- PCH, PCH, DL (Done=0), then SB_ADH=1 with Done=1.
- Repeat with Page_Cross=0 and Force_Fixup=1 -> same 4 cycles.
REQ-024 Mode 4 with Page_Cross=0 -> PCH, Zero both, Zero both, then DL with Done=1; Busy=1 for exactly 4 cycles.
REQ-025 Mode 1 with Stall=1 held 2 cycles during ZP_ACC -> Zero controls held for 3 cycles total, Done=1 only in the final unstalled cycle; a Start during the stall is ignored.
REQ-026 Mode 0 Start, then Start with Mode 2 in its Done cycle -> PCH, PCH, PCH, DL with no idle gap; Done=1 in cycles 1 and 4.
REQ-027 Abort in FETCH_HI of mode 2 -> IDLE next cycle with no Done. Separately, Start with Mode 6 -> Error=1 for one cycle, Busy=0. Separately, rst_n=0 in EFF -> immediate IDLE with all outputs 0.
